// File: rtl/dlsc_demosaic_vng6_ctrl.sv
// -----------------------------------------------------------------------------
// dlsc_demosaic_vng6_ctrl
//
// Frame-level sequencer for the VNG6 demosaic datapath. It accepts a raw Bayer
// pixel stream, drives the shared per-pixel state counter (dp_st), the datapath
// clock enable and the pixel push strobes. After the last input row it injects
// two masked all-zero rows so the datapath can drain its two-row output lag.
// The pipeline is throttled against a credit-based downstream buffer.
//
// Optional statistics: define DLSC_DEMOSAIC_VNG6_CTRL_STATS_EN to build the
// 32-bit saturating starvation/backpressure counters. Without it the stat_*
// ports are tied to zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_width/height      frame size minus one (latched on an accepted cfg_go)
//   cfg_first_red         1 = frame row 0 is a red row
//   cfg_go                start-of-frame pulse, honoured only when idle
//   busy, frame_done      status; frame_done is a one-cycle pulse
//   in_valid/ready/data   input pixel handshake
//   dp_clk_en, dp_st      datapath clock enable and pixel-period state
//   dp_px_*               push strobe and qualifiers for the pushed pixel
//   dp_out_valid          datapath produced a pixel (qualified by dp_clk_en)
//   out_credit_return     downstream freed one buffer slot
//   stat_starve/backpressure  stall statistics
// -----------------------------------------------------------------------------
module dlsc_demosaic_vng6_ctrl #(
   parameter int DATA        = 8,
   parameter int XB          = 12,
   parameter int YB          = 12,
   parameter int STATES      = 12,
   parameter int OUT_CREDITS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XB-1:0]   cfg_width,
   input  logic [YB-1:0]   cfg_height,
   input  logic            cfg_first_red,
   input  logic            cfg_go,
   output logic            busy,
   output logic            frame_done,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DATA-1:0] in_data,
   output logic            dp_clk_en,
   output logic [3:0]      dp_st,
   output logic            dp_px_push,
   output logic            dp_px_masked,
   output logic            dp_px_last,
   output logic            dp_px_row_red,
   output logic [DATA-1:0] dp_px_in,
   input  logic            dp_out_valid,
   input  logic            out_credit_return,
   output logic [31:0]     stat_starve,
   output logic [31:0]     stat_backpressure
);

   localparam int         OCW      = XB + YB + 2;
   localparam logic [3:0] ST_LAST  = 4'(STATES - 1);
   localparam logic [3:0] CRED_MAX = 4'(OUT_CREDITS);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t          state_q;
   logic [3:0]      st_q, st_d;
   logic [3:0]      credits_q, credits_d;
   logic [XB-1:0]   width_q, col_q;
   logic [YB-1:0]   height_q, row_q;
   logic            first_red_q;
   logic [1:0]      frow_q;          // completed flush rows
   logic [OCW-1:0]  out_cnt_q, out_cnt_d, total_w;
   logic [XB:0]     wp1_w;
   logic [YB:0]     hp1_w;
   logic            frame_done_q;

   logic busy_w, st0_w, pend_w, stall_w, clk_en_w, push_w, out_qual_w, last_col_w;

   always_comb begin
      busy_w     = (state_q != IDLE);
      st0_w      = (st_q == 4'd0);
      // FLUSH keeps cycling st after its last push until the output count completes
      pend_w     = (state_q == RUN) || ((state_q == FLUSH) && (frow_q != 2'd2));
      // stall only at a pixel-period boundary; a started period always runs to the end
      stall_w    = st0_w && ((credits_q == 4'd0) || ((state_q == RUN) && !in_valid));
      clk_en_w   = busy_w && !stall_w;
      push_w     = clk_en_w && st0_w && pend_w;
      out_qual_w = dp_out_valid && clk_en_w;
      last_col_w = (col_q == width_q);
      st_d       = (st_q == ST_LAST) ? 4'd0 : st_q + 4'd1;
      out_cnt_d  = out_cnt_q + OCW'(out_qual_w);
      wp1_w      = {1'b0, width_q} + (XB+1)'(1);
      hp1_w      = {1'b0, height_q} + (YB+1)'(1);
      total_w    = OCW'(wp1_w) * OCW'(hp1_w);

      // a consume and a return in the same cycle cancel; returns saturate at full
      credits_d = credits_q;
      if (out_qual_w && !out_credit_return) begin
         if (credits_q != 4'd0) credits_d = credits_q - 4'd1;
      end else if (!out_qual_w && out_credit_return && (credits_q != CRED_MAX)) begin
         credits_d = credits_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         st_q         <= 4'd0;
         credits_q    <= CRED_MAX;
         width_q      <= '0;
         height_q     <= '0;
         first_red_q  <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         frow_q       <= 2'd0;
         out_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         credits_q    <= credits_d;
         if (clk_en_w)   st_q      <= st_d;
         if (out_qual_w) out_cnt_q <= out_cnt_d;
         if (push_w) begin
            if (last_col_w) begin
               col_q <= '0;
               row_q <= row_q + YB'(1);
            end else begin
               col_q <= col_q + XB'(1);
            end
         end
         case (state_q)
            IDLE: begin
               if (cfg_go) begin
                  width_q     <= cfg_width;
                  height_q    <= cfg_height;
                  first_red_q <= cfg_first_red;
                  col_q       <= '0;
                  row_q       <= '0;
                  frow_q      <= 2'd0;
                  out_cnt_q   <= '0;
                  st_q        <= 4'd0;
                  state_q     <= RUN;
               end
            end
            RUN: begin
               if (push_w && last_col_w && (row_q == height_q)) state_q <= FLUSH;
            end
            FLUSH: begin
               if (push_w && last_col_w) frow_q <= frow_q + 2'd1;
               if (clk_en_w && (st_q == ST_LAST) && (out_cnt_d >= total_w)) begin
                  state_q      <= IDLE;
                  frame_done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy          = busy_w;
   assign frame_done    = frame_done_q;
   assign in_ready      = push_w && (state_q == RUN);
   assign dp_clk_en     = clk_en_w;
   assign dp_st         = st_q;
   assign dp_px_push    = push_w;
   assign dp_px_masked  = push_w && (state_q == FLUSH);
   assign dp_px_last    = push_w && last_col_w;
   // red row when the row parity matches the latched first-row colour
   assign dp_px_row_red = push_w && ((row_q[0] == 1'b0) == first_red_q);
   assign dp_px_in      = (state_q == RUN) ? in_data : '0;

`ifdef DLSC_DEMOSAIC_VNG6_CTRL_STATS_EN
   logic [31:0] starve_q, bp_q;
   logic        starve_ev, bp_ev;

   always_comb begin
      // backpressure takes precedence when both causes are present
      bp_ev     = busy_w && st0_w && (credits_q == 4'd0);
      starve_ev = busy_w && st0_w && (credits_q != 4'd0) && (state_q == RUN) && !in_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
         bp_q     <= '0;
      end else if ((state_q == IDLE) && cfg_go) begin
         starve_q <= '0;
         bp_q     <= '0;
      end else begin
         if (starve_ev && (starve_q != '1)) starve_q <= starve_q + 32'd1;
         if (bp_ev && (bp_q != '1))         bp_q     <= bp_q + 32'd1;
      end
   end

   assign stat_starve       = starve_q;
   assign stat_backpressure = bp_q;
`else
   assign stat_starve       = '0;
   assign stat_backpressure = '0;
`endif

endmodule

// File: tb/tb_dlsc_demosaic_vng6_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for dlsc_demosaic_vng6_ctrl. A single stimulus/monitor process advances
// one clock per tick: inputs are driven 1 time unit after the rising edge and
// outputs are sampled on the falling edge. Expected pushes are queued when a
// frame is started and compared as the DUT pushes. A small datapath model emits
// one output per pushed pixel after a two-row lag, at the last state of the
// pixel period.
// -----------------------------------------------------------------------------
module tb_dlsc_demosaic_vng6_ctrl;

   localparam int DATA        = 8;
   localparam int XB          = 12;
   localparam int YB          = 12;
   localparam int STATES      = 12;
   localparam int OUT_CREDITS = 1;

   typedef struct packed {
      logic [DATA-1:0] d;
      logic            m;
      logic            l;
      logic            r;
   } px_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [XB-1:0]   cfg_width;
   logic [YB-1:0]   cfg_height;
   logic            cfg_first_red;
   logic            cfg_go;
   logic            busy, frame_done;
   logic            in_valid, in_ready;
   logic [DATA-1:0] in_data;
   logic            dp_clk_en;
   logic [3:0]      dp_st;
   logic            dp_px_push, dp_px_masked, dp_px_last, dp_px_row_red;
   logic [DATA-1:0] dp_px_in;
   logic            dp_out_valid, out_credit_return;
   logic [31:0]     stat_starve, stat_backpressure;

   dlsc_demosaic_vng6_ctrl #(
      .DATA(DATA), .XB(XB), .YB(YB), .STATES(STATES), .OUT_CREDITS(OUT_CREDITS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_first_red(cfg_first_red),
      .cfg_go(cfg_go), .busy(busy), .frame_done(frame_done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .dp_clk_en(dp_clk_en), .dp_st(dp_st), .dp_px_push(dp_px_push),
      .dp_px_masked(dp_px_masked), .dp_px_last(dp_px_last), .dp_px_row_red(dp_px_row_red),
      .dp_px_in(dp_px_in), .dp_out_valid(dp_out_valid), .out_credit_return(out_credit_return),
      .stat_starve(stat_starve), .stat_backpressure(stat_backpressure)
   );

   initial forever #5 clk = ~clk;

`ifdef DLSC_DEMOSAIC_VNG6_CTRL_STATS_EN
   localparam logic [31:0] EXP_STARVE = 32'd20;
   localparam logic [31:0] EXP_BP     = 32'd5;
`else
   localparam logic [31:0] EXP_STARVE = 32'd0;
   localparam logic [31:0] EXP_BP     = 32'd0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   px_t             sbq[$];
   logic [DATA-1:0] inq[$];
   int owed, pushes, lag, cyc, last_push_cyc, last_out_cyc;
   bit hold, imm_ret, ret_pend, chk_gap;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      px_t e;
      @(posedge clk);
      cyc++;
      #1;
      cfg_go            = 1'b0;
      in_valid          = !hold && (inq.size() > 0);
      in_data           = (inq.size() > 0) ? inq[0] : '0;
      dp_out_valid      = (owed > 0) && busy && (dp_st == 4'(STATES - 1));
      out_credit_return = (imm_ret && dp_out_valid) || ret_pend;
      ret_pend          = 1'b0;
      @(negedge clk);
      if (dp_px_push) begin
         if (sbq.size() == 0) begin
            chk("push_unexpected", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("px", {dp_px_in, dp_px_masked, dp_px_last, dp_px_row_red}, e);
         end
         if (chk_gap && (last_push_cyc >= 0)) chk("push_gap", cyc - last_push_cyc, STATES);
         last_push_cyc = cyc;
         pushes++;
         if (pushes > lag) owed++;
      end
      if (in_valid && in_ready && (inq.size() > 0)) void'(inq.pop_front());
      if (dp_out_valid && dp_clk_en) begin
         owed--;
         last_out_cyc = cyc;
      end
   endtask

   task automatic start_frame(input int w, input int h, input bit fr);
      px_t e;
      sbq.delete();
      inq.delete();
      owed          = 0;
      pushes        = 0;
      lag           = 2 * (w + 1);
      last_push_cyc = -1;
      for (int r = 0; r <= h + 2; r++) begin
         for (int c = 0; c <= w; c++) begin
            e.m = (r > h);
            e.d = e.m ? '0 : DATA'($urandom);
            e.l = (c == w);
            e.r = (((r % 2) == 0) == fr);
            if (!e.m) inq.push_back(e.d);
            sbq.push_back(e);
         end
      end
      cfg_width     = XB'(w);
      cfg_height    = YB'(h);
      cfg_first_red = fr;
      cfg_go        = 1'b1;
   endtask

   task automatic run_to_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (frame_done) seen = 1'b1;
      end
      chk("frame_done_seen", seen, 1);
      if (seen) begin
         chk("busy_at_done", busy, 0);
         chk("done_latency", cyc - last_out_cyc, 1);
         chk("sb_drained", sbq.size(), 0);
         chk("outs_owed", owed, 0);
      end
   endtask

   initial begin
      bit found;
      int bad;
      rst_n = 1'b0; cfg_width = '0; cfg_height = '0; cfg_first_red = 1'b0; cfg_go = 1'b0;
      in_valid = 1'b0; in_data = '0; dp_out_valid = 1'b0; out_credit_return = 1'b0;
      owed = 0; pushes = 0; lag = 0; cyc = 0; last_push_cyc = -1; last_out_cyc = 0;
      hold = 1'b0; imm_ret = 1'b1; ret_pend = 1'b0; chk_gap = 1'b1;

      tick();
      tick();
      chk("rst_flags", {busy, frame_done, in_ready, dp_clk_en, dp_px_push,
                        dp_px_masked, dp_px_last, dp_px_row_red}, 0);
      chk("rst_st", dp_st, 0);
      chk("rst_px_in", dp_px_in, 0);
      rst_n = 1'b1;
      tick();

      // frame 1: 4x2, first row not red, free-running
      start_frame(3, 1, 1'b0);
      tick();
      chk("f1_busy", busy, 1);
      run_to_done(1000);

      // frame 2: 4x4, 20-cycle input starvation, cfg_go while running
      chk_gap = 1'b0;
      start_frame(3, 3, 1'b1);
      for (int i = 0; i < 100 && pushes < 3; i++) tick();
      hold  = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (dp_st == 4'd0 && !dp_clk_en) found = 1'b1;
      end
      chk("starve_reached", found, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (dp_clk_en !== 1'b0 || dp_st !== 4'd0 || in_ready !== 1'b0) bad++;
         if (i == 19) hold = 1'b0;
         tick();
      end
      chk("starve_hold", bad, 0);
      chk("starve_resume_push", dp_px_push, 1);
      chk("starve_resume_rdy", in_ready, 1);
      repeat (5) tick();
      cfg_width = '0; cfg_height = '0; cfg_first_red = 1'b0; cfg_go = 1'b1;
      tick();
      chk("go_ignored_busy", busy, 1);
      run_to_done(2000);
      chk("stat_starve", stat_starve, EXP_STARVE);
      chk("stat_bp_f2", stat_backpressure, 0);

      // frame 3: credits withheld, single return, then reset mid-row
      imm_ret = 1'b0;
      start_frame(3, 3, 1'b0);
      tick();
      chk("stat_starve_clr", stat_starve, 0);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         tick();
         if (dp_out_valid && dp_clk_en) found = 1'b1;
      end
      chk("bp_first_out", found, 1);
      tick();
      chk("bp_stall_en", dp_clk_en, 0);
      chk("bp_stall_st", dp_st, 0);
      repeat (3) tick();
      chk("bp_hold_en", dp_clk_en, 0);
      ret_pend = 1'b1;
      tick();
      tick();
      chk("bp_restart_push", dp_px_push, 1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (!dp_clk_en) found = 1'b1;
      end
      chk("bp_second_stall", found, 1);
      chk("stat_bp", stat_backpressure, EXP_BP);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_flags", {busy, frame_done, in_ready, dp_clk_en, dp_px_push,
                         dp_px_masked, dp_px_last, dp_px_row_red}, 0);
      chk("arst_st", dp_st, 0);
      chk("arst_px_in", dp_px_in, 0);
      chk("arst_stat_bp", stat_backpressure, 0);
      sbq.delete();
      inq.delete();
      owed = 0;
      imm_ret = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // frame 4: minimum 2x1 frame, first row red; needs restored credits
      chk_gap = 1'b1;
      start_frame(1, 0, 1'b1);
      run_to_done(500);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
